stats_multi_tracker_collector: RTL and testbench

- Parametrised successor to the single-tracker stats datapath; collects statistics rings from up to NUM_TRACKERS tracker tiles for one flow request.
- Per selected tracker: fetches ring metadata, computes the entry count with wrap handling, emits a length header line, then forwards the dump data as a fixed-length stream.
- Finishes with one TX notification carrying total payload length and the advanced tail pointer.

---
 rtl/stats_multi_tracker_collector.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_stats_multi_tracker_collector.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stats_multi_tracker_collector.sv
// stats_multi_tracker_collector
//
// Gathers the statistics rings of up to NUM_TRACKERS tracker tiles for one
// flow request. It visits every tracker selected in the request mask, in
// ascending index order. For each one it queries the ring metadata, works out
// the entry count, emits a header line carrying the byte length and the
// tracker id, then streams the dump as exactly ceil(bytes/DATA_BYTES) lines.
// Short dumps are padded with zero lines and long dumps are truncated. Either
// case raises a one-cycle err_len_mismatch_o pulse. Once every selected
// tracker is done, a single TX notification carries the total payload length
// and the advanced tail pointer.
//
// Ports (all val/rdy pairs transfer on val && rdy):
//   clk, rst                    clock, asynchronous active-high reset
//   req_*                       collection request: mask of trackers, tail ptr
//   meta_req_* / meta_resp_*    ring metadata query / response (start, end)
//   dump_req_*                  dump command to tracker (id, start, end)
//   data_in_*                   dump data stream from trackers
//   data_out_*                  payload stream (headers + data lines)
//   notif_*                     TX notification: total length, new tail ptr
//   err_len_mismatch_o          pulse when a dump length disagrees with n
module stats_multi_tracker_collector #(
    parameter int DATA_W       = 512,
    parameter int ADDR_W       = 8,
    parameter int STATS_BYTES  = 64,
    parameter int NUM_TRACKERS = 4,
    parameter int PTR_W        = 32,
    localparam int ID_W        = (NUM_TRACKERS > 1) ? $clog2(NUM_TRACKERS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_val_i,
    output logic                    req_rdy_o,
    input  logic [NUM_TRACKERS-1:0] req_mask_i,
    input  logic [PTR_W-1:0]        req_tail_ptr_i,
    output logic                    meta_req_val_o,
    input  logic                    meta_req_rdy_i,
    output logic [ID_W-1:0]         meta_req_id_o,
    input  logic                    meta_resp_val_i,
    output logic                    meta_resp_rdy_o,
    input  logic [ADDR_W-1:0]       meta_resp_start_i,
    input  logic [ADDR_W-1:0]       meta_resp_end_i,
    output logic                    dump_req_val_o,
    input  logic                    dump_req_rdy_i,
    output logic [ID_W-1:0]         dump_req_id_o,
    output logic [ADDR_W-1:0]       dump_req_start_o,
    output logic [ADDR_W-1:0]       dump_req_end_o,
    input  logic                    data_in_val_i,
    output logic                    data_in_rdy_o,
    input  logic [DATA_W-1:0]       data_in_data_i,
    input  logic                    data_in_last_i,
    output logic                    data_out_val_o,
    input  logic                    data_out_rdy_i,
    output logic [DATA_W-1:0]       data_out_data_o,
    output logic                    data_out_last_o,
    output logic                    notif_val_o,
    input  logic                    notif_rdy_i,
    output logic [PTR_W-1:0]        notif_len_o,
    output logic [PTR_W-1:0]        notif_tail_ptr_o,
    output logic                    err_len_mismatch_o
);
    localparam int DATA_BYTES = DATA_W / 8;
    localparam int SB_LOG     = $clog2(STATS_BYTES);
    localparam int DB_LOG     = $clog2(DATA_BYTES);
    localparam int N_W        = ADDR_W + 1;
    localparam int BYTES_W    = N_W + SB_LOG;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_META_REQ,
        ST_META_WAIT,
        ST_HDR_OUT,
        ST_DUMP_REQ,
        ST_DATA_PASS,
        ST_NOTIF
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_TRACKERS-1:0] rem_q, rem_d;        // selected trackers not yet visited
    logic [ID_W-1:0]         id_q, id_d;
    logic [PTR_W-1:0]        tail_q, tail_d;
    logic [PTR_W-1:0]        total_q, total_d;
    logic [ADDR_W-1:0]       start_q, start_d;
    logic [ADDR_W-1:0]       end_q, end_d;
    logic [BYTES_W-1:0]      bytes_q, bytes_d;
    logic [BYTES_W-1:0]      lines_q, lines_d;
    logic [BYTES_W-1:0]      cnt_q, cnt_d;        // output lines emitted for this dump
    logic                    in_done_q, in_done_d; // input stream has delivered last
    logic                    dropped_q, dropped_d; // an excess line was already dropped
    logic                    err_q, err_d;

    // Lowest set bit of a mask; used both for the first pick from the request
    // and for hopping to the next tracker, so cleared bits cost no cycles.
    function automatic logic [ID_W-1:0] first_set(input logic [NUM_TRACKERS-1:0] m);
        first_set = '0;
        for (int i = NUM_TRACKERS - 1; i >= 0; i--) begin
            if (m[i]) first_set = ID_W'(i);
        end
    endfunction

    logic [NUM_TRACKERS-1:0] pick_src;
    logic [ID_W-1:0]         pick_id;
    logic [NUM_TRACKERS-1:0] pick_rest;

    assign pick_src  = (state_q == ST_IDLE) ? req_mask_i : rem_q;
    assign pick_id   = first_set(pick_src);
    assign pick_rest = pick_src & ~(NUM_TRACKERS'(1) << pick_id);

    // Entry count is the modular ring distance end - start. start == end means
    // an empty ring and end + 1 == start means a full one (2^ADDR_W - 1
    // entries). A ring whose end lies below its start has wrapped past the top
    // of the address space and still yields the short forward distance.
    logic [ADDR_W-1:0]  ring_diff;
    logic [N_W-1:0]     n_resp;
    logic [BYTES_W-1:0] bytes_resp;
    logic [BYTES_W:0]   bytes_round;
    logic [BYTES_W-1:0] lines_resp;

    assign ring_diff   = meta_resp_end_i - meta_resp_start_i;
    assign n_resp      = {1'b0, ring_diff};
    assign bytes_resp  = BYTES_W'(n_resp) << SB_LOG;
    assign bytes_round = {1'b0, bytes_resp} + (BYTES_W + 1)'(DATA_BYTES - 1);
    assign lines_resp  = BYTES_W'(bytes_round >> DB_LOG);

    logic               last_trk;
    logic [BYTES_W-1:0] cnt_inc;
    logic [DATA_W-1:0]  hdr_line;
    logic               advance;

    assign last_trk = (rem_q == '0);
    assign cnt_inc  = cnt_q + BYTES_W'(1);

    always_comb begin
        hdr_line                       = '0;
        hdr_line[BYTES_W-1:0]          = bytes_q;
        hdr_line[DATA_W-1 -: ID_W]     = id_q;
    end

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        id_d      = id_q;
        tail_d    = tail_q;
        total_d   = total_q;
        start_d   = start_q;
        end_d     = end_q;
        bytes_d   = bytes_q;
        lines_d   = lines_q;
        cnt_d     = cnt_q;
        in_done_d = in_done_q;
        dropped_d = dropped_q;
        err_d     = 1'b0;
        advance   = 1'b0;

        req_rdy_o        = 1'b0;
        meta_req_val_o   = 1'b0;
        meta_req_id_o    = '0;
        meta_resp_rdy_o  = 1'b0;
        dump_req_val_o   = 1'b0;
        dump_req_id_o    = '0;
        dump_req_start_o = '0;
        dump_req_end_o   = '0;
        data_in_rdy_o    = 1'b0;
        data_out_val_o   = 1'b0;
        data_out_data_o  = '0;
        data_out_last_o  = 1'b0;
        notif_val_o      = 1'b0;
        notif_len_o      = '0;
        notif_tail_ptr_o = '0;

        case (state_q)
            ST_IDLE: begin
                // Held low while rst is asserted so reset shows all-zero outputs.
                req_rdy_o = ~rst;
                if (req_val_i) begin
                    tail_d  = req_tail_ptr_i;
                    total_d = '0;
                    if (req_mask_i == '0) begin
                        rem_d   = '0;
                        state_d = ST_NOTIF;
                    end else begin
                        id_d    = pick_id;
                        rem_d   = pick_rest;
                        state_d = ST_META_REQ;
                    end
                end
            end
            ST_META_REQ: begin
                meta_req_val_o = 1'b1;
                meta_req_id_o  = id_q;
                if (meta_req_rdy_i) state_d = ST_META_WAIT;
            end
            ST_META_WAIT: begin
                meta_resp_rdy_o = 1'b1;
                if (meta_resp_val_i) begin
                    start_d = meta_resp_start_i;
                    end_d   = meta_resp_end_i;
                    bytes_d = bytes_resp;
                    lines_d = lines_resp;
                    total_d = total_q + PTR_W'(DATA_BYTES) + PTR_W'(bytes_resp);
                    state_d = ST_HDR_OUT;
                end
            end
            ST_HDR_OUT: begin
                data_out_val_o  = 1'b1;
                data_out_data_o = hdr_line;
                data_out_last_o = last_trk && (bytes_q == '0);
                if (data_out_rdy_i) begin
                    cnt_d     = '0;
                    in_done_d = 1'b0;
                    dropped_d = 1'b0;
                    if (bytes_q == '0) advance = 1'b1;
                    else               state_d = ST_DUMP_REQ;
                end
            end
            ST_DUMP_REQ: begin
                dump_req_val_o   = 1'b1;
                dump_req_id_o    = id_q;
                dump_req_start_o = start_q;
                dump_req_end_o   = end_q;
                if (dump_req_rdy_i) state_d = ST_DATA_PASS;
            end
            ST_DATA_PASS: begin
                if (cnt_q < lines_q) begin
                    data_out_last_o = last_trk && (cnt_inc == lines_q);
                    if (!in_done_q) begin
                        // Pass-through: the sink's ready steers the source directly.
                        data_out_val_o  = data_in_val_i;
                        data_out_data_o = data_in_data_i;
                        data_in_rdy_o   = data_out_rdy_i;
                        if (data_in_val_i && data_out_rdy_i) begin
                            cnt_d = cnt_inc;
                            if (data_in_last_i) begin
                                in_done_d = 1'b1;
                                if (cnt_inc < lines_q) err_d = 1'b1;
                            end
                        end
                    end else begin
                        // Source ended early: pad to the advertised length.
                        data_out_val_o = 1'b1;
                        if (data_out_rdy_i) cnt_d = cnt_inc;
                    end
                end else begin
                    // Advertised length reached: drain the rest of the source.
                    data_in_rdy_o = 1'b1;
                    if (data_in_val_i) begin
                        if (!dropped_q) err_d = 1'b1;
                        dropped_d = 1'b1;
                        if (data_in_last_i) in_done_d = 1'b1;
                    end
                end
                if ((cnt_d == lines_q) && in_done_d) advance = 1'b1;
            end
            ST_NOTIF: begin
                notif_val_o      = 1'b1;
                notif_len_o      = total_q;
                notif_tail_ptr_o = tail_q + total_q;
                if (notif_rdy_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (advance) begin
            if (rem_q != '0) begin
                id_d    = pick_id;
                rem_d   = pick_rest;
                state_d = ST_META_REQ;
            end else begin
                state_d = ST_NOTIF;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rem_q     <= '0;
            id_q      <= '0;
            tail_q    <= '0;
            total_q   <= '0;
            start_q   <= '0;
            end_q     <= '0;
            bytes_q   <= '0;
            lines_q   <= '0;
            cnt_q     <= '0;
            in_done_q <= 1'b0;
            dropped_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            id_q      <= id_d;
            tail_q    <= tail_d;
            total_q   <= total_d;
            start_q   <= start_d;
            end_q     <= end_d;
            bytes_q   <= bytes_d;
            lines_q   <= lines_d;
            cnt_q     <= cnt_d;
            in_done_q <= in_done_d;
            dropped_q <= dropped_d;
            err_q     <= err_d;
        end
    end

    assign err_len_mismatch_o = err_q;

endmodule

// File: tb/tb_stats_multi_tracker_collector.sv
// Bench for stats_multi_tracker_collector: randomized tracker responders and
// sinks, a per-request payload model built from ring distances, and literal
// expectations for the directed scenarios.
module tb_stats_multi_tracker_collector;
    localparam int DATA_W = 512;
    localparam int ADDR_W = 8;
    localparam int NT     = 4;
    localparam int PTR_W  = 32;
    localparam int ID_W   = 2;
    localparam int MAXL   = 260;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              req_val_i = 0, req_rdy_o;
    logic [NT-1:0]     req_mask_i = 0;
    logic [PTR_W-1:0]  req_tail_ptr_i = 0;
    logic              meta_req_val_o, meta_req_rdy_i = 0;
    logic [ID_W-1:0]   meta_req_id_o;
    logic              meta_resp_val_i = 0, meta_resp_rdy_o;
    logic [ADDR_W-1:0] meta_resp_start_i = 0, meta_resp_end_i = 0;
    logic              dump_req_val_o, dump_req_rdy_i = 0;
    logic [ID_W-1:0]   dump_req_id_o;
    logic [ADDR_W-1:0] dump_req_start_o, dump_req_end_o;
    logic              data_in_val_i = 0, data_in_rdy_o;
    logic [DATA_W-1:0] data_in_data_i = 0;
    logic              data_in_last_i = 0;
    logic              data_out_val_o, data_out_rdy_i = 0;
    logic [DATA_W-1:0] data_out_data_o;
    logic              data_out_last_o;
    logic              notif_val_o, notif_rdy_i = 0;
    logic [PTR_W-1:0]  notif_len_o, notif_tail_ptr_o;
    logic              err_len_mismatch_o;

    stats_multi_tracker_collector dut (
        .clk(clk), .rst(rst),
        .req_val_i(req_val_i), .req_rdy_o(req_rdy_o), .req_mask_i(req_mask_i),
        .req_tail_ptr_i(req_tail_ptr_i),
        .meta_req_val_o(meta_req_val_o), .meta_req_rdy_i(meta_req_rdy_i),
        .meta_req_id_o(meta_req_id_o),
        .meta_resp_val_i(meta_resp_val_i), .meta_resp_rdy_o(meta_resp_rdy_o),
        .meta_resp_start_i(meta_resp_start_i), .meta_resp_end_i(meta_resp_end_i),
        .dump_req_val_o(dump_req_val_o), .dump_req_rdy_i(dump_req_rdy_i),
        .dump_req_id_o(dump_req_id_o), .dump_req_start_o(dump_req_start_o),
        .dump_req_end_o(dump_req_end_o),
        .data_in_val_i(data_in_val_i), .data_in_rdy_o(data_in_rdy_o),
        .data_in_data_i(data_in_data_i), .data_in_last_i(data_in_last_i),
        .data_out_val_o(data_out_val_o), .data_out_rdy_i(data_out_rdy_i),
        .data_out_data_o(data_out_data_o), .data_out_last_o(data_out_last_o),
        .notif_val_o(notif_val_o), .notif_rdy_i(notif_rdy_i),
        .notif_len_o(notif_len_o), .notif_tail_ptr_o(notif_tail_ptr_o),
        .err_len_mismatch_o(err_len_mismatch_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [519:0] got, input logic [519:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not expected / not reached", name);
    endtask

    function automatic bit rnd(input int pct);
        return $urandom_range(0, 99) < pct;
    endfunction

    // Request configuration (written by the main process only)
    logic [NT-1:0]     t_mask = 0;
    logic [PTR_W-1:0]  t_tail = 0;
    logic [7:0]        t_start [NT];
    logic [7:0]        t_end   [NT];
    int                t_supp  [NT];
    logic [DATA_W-1:0] t_data  [NT][MAXL];
    int                rdy_pct = 100;
    int                req_issue = 0;

    // Model state and observations (written by the bfm process only)
    logic [DATA_W:0]   exp_out[$];
    int                exp_meta[$];
    logic [17:0]       exp_dump[$];
    logic [PTR_W-1:0]  exp_len, exp_tailp;
    int                exp_err;
    bit                exp_active = 0;
    int                req_served = 0;
    int                out_cnt = 0, err_cnt = 0, notif_count = 0;
    logic [DATA_W-1:0] first_out, last_out;
    logic              last_out_last;
    logic [PTR_W-1:0]  obs_len, obs_tail;

    // Payload model: per selected tracker, a header carrying n*64 bytes and
    // the id, then exactly n lines (supplied data, zero-padded if short).
    task automatic build_model();
        logic [PTR_W-1:0]  len;
        logic [DATA_W-1:0] h;
        logic [DATA_W:0]   e;
        logic [1:0]        id2;
        int n, bytes, lines;
        len = 0;
        exp_out.delete(); exp_meta.delete(); exp_dump.delete();
        exp_err = 0;
        for (int i = 0; i < NT; i++) begin
            if (t_mask[i]) begin
                id2 = 2'(i);
                exp_meta.push_back(i);
                n     = (int'(t_end[i]) - int'(t_start[i]) + 256) % 256;
                bytes = n * 64;
                lines = (bytes + 63) / 64;
                len   = len + 32'(64 + bytes);
                h = DATA_W'(bytes);
                h[DATA_W-1 -: 2] = id2;
                exp_out.push_back({1'b0, h});
                if (n > 0) begin
                    exp_dump.push_back({id2, t_start[i], t_end[i]});
                    for (int k = 0; k < lines; k++)
                        exp_out.push_back({1'b0, (k < t_supp[i]) ? t_data[i][k] : {DATA_W{1'b0}}});
                    if (t_supp[i] != lines) exp_err++;
                end
            end
        end
        if (exp_out.size() > 0) begin
            e = exp_out.pop_back();
            e[DATA_W] = 1'b1;
            exp_out.push_back(e);
        end
        exp_len    = len;
        exp_tailp  = t_tail + len;
        exp_active = 1;
    endtask

    // Responders, sinks and the per-cycle compare process
    int          meta_pend[$];
    bit          strm_on = 0;
    int          strm_id = 0, strm_k = 0;
    bit          req_acc = 0, meta_acc = 0, din_acc = 0;
    bit          ho_out = 0, ho_meta = 0, ho_dump = 0, ho_notif = 0;
    logic [DATA_W:0] ho_out_v;
    logic [ID_W-1:0] ho_meta_v;
    logic [17:0]     ho_dump_v;
    logic [63:0]     ho_notif_v;

    always @(negedge clk) begin
        if (rst) begin
            meta_pend.delete(); exp_out.delete(); exp_meta.delete(); exp_dump.delete();
            exp_active = 0; strm_on = 0;
            req_acc = 0; meta_acc = 0; din_acc = 0;
            ho_out = 0; ho_meta = 0; ho_dump = 0; ho_notif = 0;
            req_served = req_issue;
            req_val_i = 0; meta_req_rdy_i = 0; meta_resp_val_i = 0; dump_req_rdy_i = 0;
            data_in_val_i = 0; data_in_last_i = 0; data_out_rdy_i = 0; notif_rdy_i = 0;
        end else begin
            if (req_acc) req_served++;
            if (meta_acc) begin
                void'(meta_pend.pop_front());
                meta_resp_val_i = 0;
            end
            if (din_acc) begin
                strm_k++;
                if (data_in_last_i) strm_on = 0;
                data_in_val_i = 0;
            end
            req_acc = 0; meta_acc = 0; din_acc = 0;

            req_val_i      = (req_issue != req_served);
            req_mask_i     = t_mask;
            req_tail_ptr_i = t_tail;
            meta_req_rdy_i = rnd(rdy_pct);
            dump_req_rdy_i = rnd(rdy_pct);
            data_out_rdy_i = rnd(rdy_pct);
            notif_rdy_i    = rnd(rdy_pct);
            if (!meta_resp_val_i && meta_pend.size() > 0 && rnd(70)) begin
                meta_resp_val_i   = 1;
                meta_resp_start_i = t_start[meta_pend[0]];
                meta_resp_end_i   = t_end[meta_pend[0]];
            end
            if (!data_in_val_i) begin
                for (int w = 0; w < DATA_W / 32; w++) data_in_data_i[w*32 +: 32] = $urandom;
                data_in_last_i = 0;
                if (strm_on && rnd(70)) begin
                    data_in_val_i  = 1;
                    data_in_data_i = t_data[strm_id][strm_k];
                    data_in_last_i = (strm_k == t_supp[strm_id] - 1);
                end
            end

            #1;
            if (err_len_mismatch_o) err_cnt++;
            if (req_val_i && req_rdy_o) begin
                req_acc = 1;
                build_model();
                out_cnt = 0;
                err_cnt = 0;
            end
            if (meta_resp_val_i && meta_resp_rdy_o) meta_acc = 1;
            if (data_in_val_i && data_in_rdy_o) din_acc = 1;

            if (ho_out) chk("out_hold", {data_out_val_o, data_out_last_o, data_out_data_o}, {1'b1, ho_out_v});
            if (data_out_val_o && data_out_rdy_i) begin
                if (exp_out.size() == 0) fail("out_unexpected");
                else chk("out_line", {data_out_last_o, data_out_data_o}, exp_out.pop_front());
                if (out_cnt == 0) first_out = data_out_data_o;
                last_out      = data_out_data_o;
                last_out_last = data_out_last_o;
                out_cnt++;
            end
            ho_out   = data_out_val_o && !data_out_rdy_i;
            ho_out_v = {data_out_last_o, data_out_data_o};

            if (ho_meta) chk("meta_hold", {meta_req_val_o, meta_req_id_o}, {1'b1, ho_meta_v});
            if (meta_req_val_o && meta_req_rdy_i) begin
                if (exp_meta.size() == 0) fail("meta_unexpected");
                else chk("meta_id", meta_req_id_o, exp_meta.pop_front());
                meta_pend.push_back(int'(meta_req_id_o));
            end
            ho_meta   = meta_req_val_o && !meta_req_rdy_i;
            ho_meta_v = meta_req_id_o;

            if (ho_dump) chk("dump_hold", {dump_req_val_o, dump_req_id_o, dump_req_start_o, dump_req_end_o}, {1'b1, ho_dump_v});
            if (dump_req_val_o && dump_req_rdy_i) begin
                if (exp_dump.size() == 0) fail("dump_unexpected");
                else chk("dump_req", {dump_req_id_o, dump_req_start_o, dump_req_end_o}, exp_dump.pop_front());
                strm_on = 1;
                strm_id = int'(dump_req_id_o);
                strm_k  = 0;
            end
            ho_dump   = dump_req_val_o && !dump_req_rdy_i;
            ho_dump_v = {dump_req_id_o, dump_req_start_o, dump_req_end_o};

            if (ho_notif) chk("notif_hold", {notif_val_o, notif_len_o, notif_tail_ptr_o}, {1'b1, ho_notif_v});
            if (notif_val_o && notif_rdy_i) begin
                if (!exp_active) fail("notif_unexpected");
                else begin
                    chk("notif_len", notif_len_o, exp_len);
                    chk("notif_tail", notif_tail_ptr_o, exp_tailp);
                    chk("err_pulses", err_cnt, exp_err);
                    chk("payload_drained", exp_out.size() + exp_meta.size() + exp_dump.size(), 0);
                end
                exp_active = 0;
                obs_len    = notif_len_o;
                obs_tail   = notif_tail_ptr_o;
                notif_count++;
            end
            ho_notif   = notif_val_o && !notif_rdy_i;
            ho_notif_v = {notif_len_o, notif_tail_ptr_o};
        end
    end

    task automatic clear_cfg();
        for (int i = 0; i < NT; i++) begin
            t_start[i] = 0; t_end[i] = 0; t_supp[i] = 1;
        end
    endtask

    task automatic fill_data();
        for (int i = 0; i < NT; i++)
            for (int k = 0; k < t_supp[i]; k++)
                for (int w = 0; w < DATA_W / 32; w++) t_data[i][k][w*32 +: 32] = $urandom;
    endtask

    task automatic set_trk(input int i, input int s, input int n, input int supp);
        t_start[i] = 8'(s);
        t_end[i]   = 8'(s + n);
        t_supp[i]  = supp;
    endtask

    task automatic run_txn(input string name);
        int c0;
        bit seen;
        fill_data();
        @(posedge clk); #2;
        c0 = notif_count;
        req_issue++;
        seen = 0;
        for (int cyc = 0; cyc < 20000 && !seen; cyc++) begin
            @(posedge clk);
            if (notif_count != c0) seen = 1;
        end
        if (!seen) fail({name, "_timeout"});
        #2;
        $display("txn %s: mask=%b lines_out=%0d len=%0d tail=%0h err_pulses=%0d",
                 name, t_mask, out_cnt, obs_len, obs_tail, err_cnt);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_rdy_val"}, {req_rdy_o, meta_req_val_o, meta_resp_rdy_o, dump_req_val_o,
             data_in_rdy_o, data_out_val_o, notif_val_o, err_len_mismatch_o}, 0);
        chk({name, "_fields"}, {data_out_last_o, meta_req_id_o, dump_req_id_o, dump_req_start_o,
             dump_req_end_o, notif_len_o, notif_tail_ptr_o}, 0);
        chk({name, "_data"}, data_out_data_o, 0);
    endtask

    initial begin
        int c0, lines, n;
        bit hit;
        clear_cfg();
        repeat (3) @(posedge clk);
        #1 chk_all_zero("reset");
        @(posedge clk); #2 rst = 0;
        #1 chk("idle_req_rdy", req_rdy_o, 1);

        // Single tracker: n=4
        clear_cfg(); rdy_pct = 100; t_mask = 4'b0001; t_tail = 32'h1000;
        set_trk(0, 2, 4, 4);
        run_txn("single");
        chk("single_len", obs_len, 320);
        chk("single_tail", obs_tail, 32'h1140);
        chk("single_lines", out_cnt, 5);
        chk("single_hdr_bytes", first_out[14:0], 256);
        chk("single_last", last_out_last, 1);

        // Wrap: start 250, end 4 -> n=10
        clear_cfg(); rdy_pct = 60; t_mask = 4'b0001; t_tail = 32'h0;
        set_trk(0, 250, 10, 10);
        run_txn("wrap10");
        chk("wrap10_len", obs_len, 704);
        chk("wrap10_lines", out_cnt, 11);

        // Full ring: end=249, start=250 -> n=255
        clear_cfg(); t_mask = 4'b0001; t_tail = 32'h100;
        set_trk(0, 250, 255, 255);
        run_txn("wrap255");
        chk("wrap255_len", obs_len, 16384);
        chk("wrap255_lines", out_cnt, 256);

        // Skip: trackers 1 (empty) and 3 (one entry)
        clear_cfg(); t_mask = 4'b1010; t_tail = 32'h20;
        set_trk(1, 7, 0, 1); set_trk(3, 0, 1, 1);
        run_txn("skip");
        chk("skip_len", obs_len, 192);
        chk("skip_lines", out_cnt, 3);
        chk("skip_hdr_id", first_out[511:510], 1);
        chk("skip_hdr_bytes", first_out[14:0], 0);

        // Empty mask
        clear_cfg(); t_mask = 4'b0000; t_tail = 32'h1234;
        run_txn("empty");
        chk("empty_len", obs_len, 0);
        chk("empty_tail", obs_tail, 32'h1234);
        chk("empty_lines", out_cnt, 0);

        // Tail pointer wrap: one empty tracker, len 64
        clear_cfg(); t_mask = 4'b0001; t_tail = 32'hFFFF_FFF0;
        set_trk(0, 9, 0, 1);
        run_txn("tailwrap");
        chk("tailwrap_tail", obs_tail, 32'h30);
        chk("tailwrap_last", last_out_last, 1);

        // Short dump: 3 expected, last on 2nd
        clear_cfg(); t_mask = 4'b0100; t_tail = 32'h0;
        set_trk(2, 10, 3, 2);
        run_txn("short");
        chk("short_err", err_cnt, 1);
        chk("short_lines", out_cnt, 4);
        chk("short_pad_zero", last_out, 0);
        chk("short_pad_last", last_out_last, 1);

        // Long dump: 2 expected, 4 supplied
        clear_cfg(); t_mask = 4'b0001; t_tail = 32'h0;
        set_trk(0, 100, 2, 4);
        run_txn("long");
        chk("long_err", err_cnt, 1);
        chk("long_lines", out_cnt, 3);

        // Randomized requests with random backpressure
        for (int r = 0; r < 25; r++) begin
            clear_cfg();
            rdy_pct = $urandom_range(30, 100);
            t_mask  = 4'($urandom);
            t_tail  = $urandom;
            for (int i = 0; i < NT; i++) begin
                n = rnd(10) ? $urandom_range(0, 255) : $urandom_range(0, 6);
                lines = n;
                if (lines > 1 && rnd(20))      set_trk(i, $urandom_range(0, 255), n, $urandom_range(1, lines - 1));
                else if (lines > 0 && rnd(20)) set_trk(i, $urandom_range(0, 255), n, lines + $urandom_range(1, 3));
                else                           set_trk(i, $urandom_range(0, 255), n, (lines > 0) ? lines : 1);
            end
            run_txn("random");
        end

        // Reset in the middle of a dump
        clear_cfg(); rdy_pct = 100; t_mask = 4'b0001; t_tail = 32'h0;
        set_trk(0, 0, 8, 8);
        fill_data();
        @(posedge clk); #2;
        c0 = notif_count;
        req_issue++;
        hit = 0;
        for (int cyc = 0; cyc < 2000 && !hit; cyc++) begin
            @(posedge clk);
            if (req_served == req_issue && out_cnt >= 3) hit = 1;
        end
        if (!hit) fail("rst_reach_pass");
        #2 rst = 1;
        #1 chk_all_zero("midrst");
        @(posedge clk); #1 chk_all_zero("midrst_edge");
        @(posedge clk); #2 rst = 0;
        #1 chk("midrst_req_rdy", req_rdy_o, 1);
        repeat (20) @(posedge clk);
        chk("midrst_no_notif", notif_count, c0);
        $display("txn reset_abort: lines_before_reset>=3 notifs_after=%0d", notif_count - c0);

        clear_cfg(); rdy_pct = 80; t_mask = 4'b0001; t_tail = 32'h1000;
        set_trk(0, 2, 4, 4);
        run_txn("after_rst");
        chk("after_rst_len", obs_len, 320);
        chk("after_rst_err", err_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
